// File: rtl/t00_wb_ctrl_regs_if.sv
// Wishbone classic bus bundle between the management core and the sequencer control regs.
// Signal names keep the slave-side _i/_o view so the register bank reads naturally.
interface t00_wb_ctrl_regs_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/t00_wb_ctrl_regs.sv
// Wishbone register bank for the GPIO sequencer: prescaler, done status/run counter, irq.
// Ack and read data one cycle after the request; never stalls, at most one ack every other cycle.
module t00_wb_ctrl_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h5445_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  t00_wb_ctrl_regs_if.slave        wb,
  input  logic                     done_i,
  output logic [13:0]              prescaler_o,
  output logic                     irq_o
);

  localparam logic [1:0] REG_PRESC  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IRQEN  = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [13:0] presc_q, presc_d;
  logic        done_sts_q, done_sts_d;
  logic [7:0]  runs_q, runs_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q;

  logic        req;
  logic        hit;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  reg_idx;
  logic        done_rise;
  logic [31:0] rdata;
  logic [15:0] presc_wr;
  logic        status_wr;
  logic        w1c_done;
  logic        clr_runs;

  // The ~ack_q term keeps a lingering strobe from being acked twice in a row.
  assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign hit       = (wb.wb_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_en     = req & wb.wb_we_i & hit;
  assign rd_en     = req & ~wb.wb_we_i;
  assign reg_idx   = wb.wb_adr_i[3:2];
  assign done_rise = done_i & ~done_q;

  assign status_wr = wr_en && (reg_idx == REG_STATUS) && wb.wb_sel_i[0];
  assign w1c_done  = status_wr & wb.wb_dat_i[0];
  assign clr_runs  = status_wr & wb.wb_dat_i[1];

  // Merge enabled byte lanes 0/1 over the current value before the zero check.
  assign presc_wr = {
    wb.wb_sel_i[1] ? wb.wb_dat_i[15:8] : {2'b00, presc_q[13:8]},
    wb.wb_sel_i[0] ? wb.wb_dat_i[7:0]  : presc_q[7:0]
  };

  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (reg_idx)
        REG_PRESC:  rdata = {18'h0, presc_q};
        REG_STATUS: rdata = {16'h0, runs_q, 7'h0, done_sts_q};
        REG_IRQEN:  rdata = {31'h0, irq_en_q};
        REG_ID:     rdata = ID_VALUE;
        default:    rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    ack_d = req;
    dat_d = rd_en ? rdata : 32'h0;
  end

  always_comb begin
    presc_d  = presc_q;
    irq_en_d = irq_en_q;
    if (wr_en && (reg_idx == REG_PRESC)) begin
      presc_d = (presc_wr[13:0] == 14'd0) ? 14'd1 : presc_wr[13:0];
    end
    if (wr_en && (reg_idx == REG_IRQEN) && wb.wb_sel_i[0]) begin
      irq_en_d = wb.wb_dat_i[0];
    end
  end

  // A rise on the same edge as a clear wins, so no edge is ever lost.
  always_comb begin
    done_sts_d = done_sts_q;
    runs_d     = runs_q;
    if (w1c_done) begin
      done_sts_d = 1'b0;
    end
    if (clr_runs) begin
      runs_d = 8'd0;
    end
    if (done_rise) begin
      done_sts_d = 1'b1;
      if (clr_runs) begin
        runs_d = 8'd1;
      end else if (runs_q != 8'hFF) begin
        runs_d = runs_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      presc_q    <= 14'd1;
      done_sts_q <= 1'b0;
      runs_q     <= 8'd0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      presc_q    <= presc_d;
      done_sts_q <= done_sts_d;
      runs_q     <= runs_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_i;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign prescaler_o = presc_q;
  assign irq_o       = done_sts_q & irq_en_q;

  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i[31:16], wb.wb_sel_i[3:2], presc_wr[15:14]};

endmodule
